scrub_sequencer: RTL and testbench

Periodic and on-demand configuration-memory scrub controller for the XCAU25P edge node. It owns the frame-ECC readback path: it walks frame addresses, issues one readback per frame, and classifies the ECC result. For each single-bit upset it issues a correction write-back request; multi-bit upsets are latched as uncorrectable. It replaces the free-running scrub pulse with a sequenced, observable sweep and sits between the system clock domain and the frame read/fix engine.

---
 rtl/scrub_pkg.sv | 23 ++
 rtl/scrub_sequencer_if.sv | 32 +++
 rtl/scrub_period_timer.sv | 30 +++
 rtl/scrub_sequencer.sv | 172 +++++++++++++++++
 tb/tb_scrub_sequencer.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/scrub_pkg.sv
// Shared types for the configuration-memory scrub sequencer:
// FSM state encoding and the ECC fix-location record.
package scrub_pkg;

  localparam int ECC_WORD_W = 7;
  localparam int ECC_BIT_W  = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_ECC,
    ST_FIX,
    ST_NEXT
  } state_e;

  // Word/bit location of a correctable flip; the frame address is added by the
  // sequencer, whose address width is a module parameter.
  typedef struct packed {
    logic [ECC_WORD_W-1:0] word;
    logic [ECC_BIT_W-1:0]  bit_idx;
  } fix_loc_t;

endpackage

// File: rtl/scrub_sequencer_if.sv
// Readback / ECC / correction bus between the scrub sequencer (master)
// and the frame read/fix engine (slave).
interface scrub_sequencer_if #(
  parameter int FAW = 12
);
  import scrub_pkg::*;

  logic                  rd_req;
  logic [FAW-1:0]        rd_addr;
  logic                  rd_ack;
  logic                  ecc_valid;
  logic                  ecc_error;
  logic                  ecc_single;
  logic [ECC_WORD_W-1:0] ecc_word;
  logic [ECC_BIT_W-1:0]  ecc_bit;
  logic                  fix_req;
  logic [FAW-1:0]        fix_addr;
  logic [ECC_WORD_W-1:0] fix_word;
  logic [ECC_BIT_W-1:0]  fix_bit;
  logic                  fix_done;

  modport master (
    output rd_req, rd_addr, fix_req, fix_addr, fix_word, fix_bit,
    input  rd_ack, ecc_valid, ecc_error, ecc_single, ecc_word, ecc_bit, fix_done
  );

  modport slave (
    input  rd_req, rd_addr, fix_req, fix_addr, fix_word, fix_bit,
    output rd_ack, ecc_valid, ecc_error, ecc_single, ecc_word, ecc_bit, fix_done
  );

endinterface

// File: rtl/scrub_period_timer.sv
// Idle-time period counter: advances while run=1, holds otherwise, and
// flags expiry on its last count so the sequencer can launch a sweep.
module scrub_period_timer #(
  parameter int PERIOD_CYCLES = 1_000_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic expire
);

  localparam int TW = (PERIOD_CYCLES > 2) ? $clog2(PERIOD_CYCLES) : 1;
  localparam logic [TW-1:0] LAST = TW'(PERIOD_CYCLES - 1);

  logic [TW-1:0] count;

  assign expire = run && (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || expire) begin
      count <= '0;
    end else if (run) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/scrub_sequencer.sv
// Frame-ECC scrub sequencer: walks frames, issues readbacks, requests
// single-bit corrections and records uncorrectable upsets and watchdog trips.
module scrub_sequencer
  import scrub_pkg::*;
#(
  parameter int PERIOD_CYCLES  = 1_000_000_000,
  parameter int NUM_FRAMES     = 4096,
  parameter int FAW            = 12,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_100mhz,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  force_scrub,
  input  logic                  clear_status,
  scrub_sequencer_if.master     bus,
  output logic                  scrub_active,
  output logic                  sweep_done,
  output logic [CNT_W-1:0]      corr_count,
  output logic                  uncorr_flag,
  output logic [FAW-1:0]        uncorr_addr,
  output logic                  timeout_flag
);

  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LAST    = WDW'(TIMEOUT_CYCLES - 1);
  localparam logic [FAW-1:0] LAST_FRAME = FAW'(NUM_FRAMES - 1);

  typedef struct packed {
    logic [FAW-1:0] addr;
    fix_loc_t       loc;
  } fix_rec_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_e         state, state_nxt;
  logic [FAW-1:0] frame, frame_nxt;
  logic           periodic, periodic_nxt;
  fix_rec_t       fix_rec, fix_rec_nxt;
  logic [WDW-1:0] wd, wd_nxt;
  logic [CNT_W-1:0] corr_nxt;
  logic           uflag_nxt, tflag_nxt, done_nxt, start;
  logic [FAW-1:0] uaddr_nxt;
  logic           rd_req_reg, fix_req_reg;
  logic           expire;

  scrub_period_timer #(.PERIOD_CYCLES(PERIOD_CYCLES)) u_timer (
    .clk    (clk_100mhz),
    .rst    (rst),
    .run    ((state == ST_IDLE) && enable),
    .clear  (start),
    .expire (expire)
  );

  always_comb begin
    state_nxt    = state;
    frame_nxt    = frame;
    periodic_nxt = periodic;
    fix_rec_nxt  = fix_rec;
    wd_nxt       = '0;
    corr_nxt     = clear_status ? '0 : corr_count;
    uflag_nxt    = clear_status ? 1'b0 : uncorr_flag;
    uaddr_nxt    = clear_status ? '0 : uncorr_addr;
    tflag_nxt    = clear_status ? 1'b0 : timeout_flag;
    done_nxt     = 1'b0;
    start        = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // A forced start wins over a coincident expiry and ignores enable.
        if (force_scrub || expire) begin
          start        = 1'b1;
          state_nxt    = ST_REQ;
          frame_nxt    = '0;
          periodic_nxt = !force_scrub;
        end
      end
      ST_REQ: begin
        if (bus.rd_ack) state_nxt = ST_WAIT_ECC;
      end
      ST_WAIT_ECC: begin
        if (bus.ecc_valid) begin
          if (!bus.ecc_error) begin
            state_nxt = ST_NEXT;
          end else if (bus.ecc_single) begin
            fix_rec_nxt.addr        = frame;
            fix_rec_nxt.loc.word    = bus.ecc_word;
            fix_rec_nxt.loc.bit_idx = bus.ecc_bit;
            state_nxt               = ST_FIX;
          end else begin
            uflag_nxt = 1'b1;
            if (!uncorr_flag || clear_status) uaddr_nxt = frame;
            state_nxt = ST_NEXT;
          end
        end else if (wd == WD_LAST) begin
          tflag_nxt = 1'b1;
          state_nxt = ST_NEXT;
        end else begin
          wd_nxt = wd + 1'b1;
        end
      end
      ST_FIX: begin
        if (bus.fix_done) begin
          corr_nxt  = sat_inc(corr_nxt);
          state_nxt = ST_NEXT;
        end else if (wd == WD_LAST) begin
          tflag_nxt = 1'b1;
          state_nxt = ST_NEXT;
        end else begin
          wd_nxt = wd + 1'b1;
        end
      end
      ST_NEXT: begin
        if (frame == LAST_FRAME) begin
          done_nxt  = 1'b1;
          frame_nxt = '0;
          state_nxt = ST_IDLE;
        end else if (!enable && periodic) begin
          frame_nxt = '0;
          state_nxt = ST_IDLE;
        end else begin
          frame_nxt = frame + 1'b1;
          state_nxt = ST_REQ;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they switch with the state.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      frame        <= '0;
      periodic     <= 1'b0;
      fix_rec      <= '0;
      wd           <= '0;
      corr_count   <= '0;
      uncorr_flag  <= 1'b0;
      uncorr_addr  <= '0;
      timeout_flag <= 1'b0;
      sweep_done   <= 1'b0;
      scrub_active <= 1'b0;
      rd_req_reg   <= 1'b0;
      fix_req_reg  <= 1'b0;
    end else begin
      state        <= state_nxt;
      frame        <= frame_nxt;
      periodic     <= periodic_nxt;
      fix_rec      <= fix_rec_nxt;
      wd           <= wd_nxt;
      corr_count   <= corr_nxt;
      uncorr_flag  <= uflag_nxt;
      uncorr_addr  <= uaddr_nxt;
      timeout_flag <= tflag_nxt;
      sweep_done   <= done_nxt;
      scrub_active <= (state_nxt != ST_IDLE);
      rd_req_reg   <= (state_nxt == ST_REQ);
      fix_req_reg  <= (state_nxt == ST_FIX);
    end
  end

  assign bus.rd_req   = rd_req_reg;
  assign bus.rd_addr  = frame;
  assign bus.fix_req  = fix_req_reg;
  assign bus.fix_addr = fix_rec.addr;
  assign bus.fix_word = fix_rec.loc.word;
  assign bus.fix_bit  = fix_rec.loc.bit_idx;

endmodule

// File: tb/tb_scrub_sequencer.sv
// Directed bench for scrub_sequencer: periodic and forced sweeps, correction,
// uncorrectable capture, watchdog, mid-sweep reset and counter saturation.
module tb_scrub_sequencer;
  import scrub_pkg::*;

  localparam int PERIOD = 100;
  localparam int NF     = 4;
  localparam int FAW    = 3;
  localparam int CNT_W  = 2;
  localparam int TO     = 16;

  logic clk_100mhz = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic force_scrub = 1'b0;
  logic clear_status = 1'b0;
  logic scrub_active, sweep_done, uncorr_flag, timeout_flag;
  logic [CNT_W-1:0] corr_count;
  logic [FAW-1:0]   uncorr_addr;

  int vectors = 0;
  int miscompares = 0;

  scrub_sequencer_if #(.FAW(FAW)) bus();

  always #5 clk_100mhz = ~clk_100mhz;

  scrub_sequencer #(
    .PERIOD_CYCLES(PERIOD), .NUM_FRAMES(NF), .FAW(FAW),
    .CNT_W(CNT_W), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_100mhz   (clk_100mhz),
    .rst          (rst),
    .enable       (enable),
    .force_scrub  (force_scrub),
    .clear_status (clear_status),
    .bus          (bus.master),
    .scrub_active (scrub_active),
    .sweep_done   (sweep_done),
    .corr_count   (corr_count),
    .uncorr_flag  (uncorr_flag),
    .uncorr_addr  (uncorr_addr),
    .timeout_flag (timeout_flag)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rd(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (bus.rd_req === 1'b1) seen = 1'b1;
      else @(negedge clk_100mhz);
    end
  endtask

  // kind: 0 clean, 1 single-bit, 2 multi-bit. Returns on the negedge after
  // the last handshake, with the sequencer in NEXT.
  task automatic serve_frame(input int addr, input int kind, input int word, input int bitv);
    bit seen;
    wait_rd(300, seen);
    check("rd_req_seen", 32'(seen), 32'd1);
    check("rd_addr", 32'(bus.rd_addr), 32'(addr));
    bus.rd_ack = 1'b1;
    @(negedge clk_100mhz);
    bus.rd_ack     = 1'b0;
    check("rd_req_drop", 32'(bus.rd_req), 32'd0);
    bus.ecc_valid  = 1'b1;
    bus.ecc_error  = (kind != 0);
    bus.ecc_single = (kind == 1);
    bus.ecc_word   = 7'(word);
    bus.ecc_bit    = 5'(bitv);
    @(negedge clk_100mhz);
    bus.ecc_valid  = 1'b0;
    bus.ecc_error  = 1'b0;
    bus.ecc_single = 1'b0;
    if (kind == 1) begin
      check("fix_req", 32'(bus.fix_req), 32'd1);
      check("fix_addr", 32'(bus.fix_addr), 32'(addr));
      check("fix_word", 32'(bus.fix_word), 32'(word));
      check("fix_bit", 32'(bus.fix_bit), 32'(bitv));
      @(negedge clk_100mhz);
      check("fix_req_hold", 32'(bus.fix_req), 32'd1);
      check("fix_addr_hold", 32'(bus.fix_addr), 32'(addr));
      bus.fix_done = 1'b1;
      @(negedge clk_100mhz);
      bus.fix_done = 1'b0;
      check("fix_req_drop", 32'(bus.fix_req), 32'd0);
    end
  endtask

  task automatic pulse_force();
    force_scrub = 1'b1;
    @(negedge clk_100mhz);
    force_scrub = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_status = 1'b1;
    @(negedge clk_100mhz);
    clear_status = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int k;
    bit seen;
    bus.rd_ack = 1'b0; bus.ecc_valid = 1'b0; bus.ecc_error = 1'b0; bus.ecc_single = 1'b0;
    bus.ecc_word = '0; bus.ecc_bit = '0; bus.fix_done = 1'b0;

    // Reset state
    repeat (3) @(negedge clk_100mhz);
    check("rst_rd_req", 32'(bus.rd_req), 32'd0);
    check("rst_fix_req", 32'(bus.fix_req), 32'd0);
    check("rst_active", 32'(scrub_active), 32'd0);
    check("rst_corr", 32'(corr_count), 32'd0);
    check("rst_flags", 32'({uncorr_flag, timeout_flag, sweep_done}), 32'd0);
    rst = 1'b0;
    enable = 1'b1;

    // Periodic sweep, all clean, then period spacing
    for (int f = 0; f < NF; f++) serve_frame(f, 0, 0, 0);
    @(negedge clk_100mhz);
    check("periodic_done", 32'(sweep_done), 32'd1);
    check("idle_active", 32'(scrub_active), 32'd0);
    @(negedge clk_100mhz);
    check("done_one_cycle", 32'(sweep_done), 32'd0);
    k = 1;
    while (bus.rd_req !== 1'b1 && k < 300) begin
      @(negedge clk_100mhz);
      k++;
    end
    check("period_gap", 32'(k), 32'd100);

    // Disable mid periodic sweep: abort at NEXT, no sweep_done
    enable = 1'b0;
    serve_frame(0, 0, 0, 0);
    @(negedge clk_100mhz);
    check("abort_done", 32'(sweep_done), 32'd0);
    check("abort_active", 32'(scrub_active), 32'd0);
    repeat (150) @(negedge clk_100mhz);
    check("held_timer_no_req", 32'(bus.rd_req), 32'd0);

    // Forced sweep with single-bit upset on frame 2
    pulse_force();
    check("force_active", 32'(scrub_active), 32'd1);
    serve_frame(0, 0, 0, 0);
    serve_frame(1, 0, 0, 0);
    serve_frame(2, 1, 5, 17);
    check("corr_one", 32'(corr_count), 32'd1);
    serve_frame(3, 0, 0, 0);
    @(negedge clk_100mhz);
    check("force_done", 32'(sweep_done), 32'd1);

    // Multi-bit upsets on frames 1 and 3: first address retained
    pulse_force();
    serve_frame(0, 0, 0, 0);
    serve_frame(1, 2, 0, 0);
    check("uncorr_flag_1", 32'(uncorr_flag), 32'd1);
    check("uncorr_addr_1", 32'(uncorr_addr), 32'd1);
    serve_frame(2, 0, 0, 0);
    serve_frame(3, 2, 0, 0);
    check("uncorr_addr_keep", 32'(uncorr_addr), 32'd1);
    @(negedge clk_100mhz);
    pulse_clear();
    check("clr_uflag", 32'(uncorr_flag), 32'd0);
    check("clr_uaddr", 32'(uncorr_addr), 32'd0);
    check("clr_corr", 32'(corr_count), 32'd0);

    // Watchdog: ecc_valid withheld on frame 0
    pulse_force();
    wait_rd(20, seen);
    check("to_rd_seen", 32'(seen), 32'd1);
    check("to_rd_addr", 32'(bus.rd_addr), 32'd0);
    bus.rd_ack = 1'b1;
    @(negedge clk_100mhz);
    bus.rd_ack = 1'b0;
    repeat (15) @(negedge clk_100mhz);
    check("to_not_yet", 32'(timeout_flag), 32'd0);
    @(negedge clk_100mhz);
    check("to_flag", 32'(timeout_flag), 32'd1);
    serve_frame(1, 0, 0, 0);
    serve_frame(2, 0, 0, 0);
    serve_frame(3, 0, 0, 0);
    @(negedge clk_100mhz);
    check("to_sweep_done", 32'(sweep_done), 32'd1);
    pulse_clear();
    check("clr_to_flag", 32'(timeout_flag), 32'd0);

    // Reset while fix_req is high
    pulse_force();
    wait_rd(20, seen);
    bus.rd_ack = 1'b1;
    @(negedge clk_100mhz);
    bus.rd_ack = 1'b0;
    bus.ecc_valid = 1'b1; bus.ecc_error = 1'b1; bus.ecc_single = 1'b1;
    bus.ecc_word = 7'd3; bus.ecc_bit = 5'd2;
    @(negedge clk_100mhz);
    bus.ecc_valid = 1'b0; bus.ecc_error = 1'b0; bus.ecc_single = 1'b0;
    check("pre_rst_fix_req", 32'(bus.fix_req), 32'd1);
    rst = 1'b1;
    #1;
    check("async_fix_req", 32'(bus.fix_req), 32'd0);
    check("async_active", 32'(scrub_active), 32'd0);
    check("async_fix_word", 32'(bus.fix_word), 32'd0);
    @(negedge clk_100mhz);
    rst = 1'b0;
    @(negedge clk_100mhz);
    check("no_resume", 32'(bus.rd_req), 32'd0);
    pulse_force();
    for (int f = 0; f < NF; f++) serve_frame(f, 0, 0, 0);
    @(negedge clk_100mhz);
    check("post_rst_done", 32'(sweep_done), 32'd1);

    // Saturation: 5 corrections on a 2-bit counter
    pulse_force();
    for (int f = 0; f < NF; f++) begin
      serve_frame(f, 1, f + 10, f + 1);
      check("corr_sat_step", 32'(corr_count), 32'((f + 1 > 3) ? 3 : f + 1));
    end
    @(negedge clk_100mhz);
    pulse_force();
    serve_frame(0, 1, 100, 31);
    check("corr_sat_hold", 32'(corr_count), 32'd3);
    for (int f = 1; f < NF; f++) serve_frame(f, 0, 0, 0);
    @(negedge clk_100mhz);
    check("sat_sweep_done", 32'(sweep_done), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
